// File: rtl/mbyte_add_seq.sv
// mbyte_add_seq: sequences an (8*NBYTES)-bit addition over an external 8-bit
// ripple-carry adder, one byte per cycle, least-significant byte first. The
// carry between bytes is held in carry_reg. Operands arrive on a valid/ready
// handshake, and the wide result leaves on a second valid/ready handshake.
module mbyte_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_a,
    input  logic [8*NBYTES-1:0]   in_b,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_sum,
    output logic                  out_cout,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_reg;
    logic [W-1:0]  sum_merge;
    logic          cin_reg;
    logic          carry_reg;
    logic [IW-1:0] idx;

    logic          accept;
    logic          running;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; handshake outputs depend on state only.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        running   = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                running = 1'b1;
                if (idx == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Select the operand bytes addressed by idx.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                a_byte = a_reg[8*i +: 8];
                b_byte = b_reg[8*i +: 8];
            end
        end
    end

    // Merge the adder's byte result into the running sum at position idx.
    always_comb begin
        sum_merge = sum_reg;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) begin
                sum_merge[8*i +: 8] = add_sum;
            end
        end
    end

    // Adder drive: quiet outside RUN; byte 0 takes the latched carry-in.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (running) begin
            add_a   = a_byte;
            add_b   = b_byte;
            add_cin = (idx == '0) ? cin_reg : carry_reg;
        end
    end

    // Operand capture at accept, then one byte result and carry per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else if (accept) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            cin_reg <= in_cin;
            idx     <= '0;
        end else if (running) begin
            sum_reg   <= sum_merge;
            carry_reg <= add_cout;
            if (idx != LAST) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = carry_reg;

endmodule
